mdu: RTL

Multiply/divide execution unit: a new responder on the conveyor dispatch bus, alongside the alu, fpu, imm, jump and mov units. It claims conveyor slots tagged for the MDU and reads two source registers. It runs an integer multiply (1 cycle) or a restoring divide (32 cycles), writes the result to the register file, then stamps the slot complete through the pool. Only one instruction is in flight at a time.

---
 rtl/mdu_pkg.sv | 59 +++++
 rtl/mdu_div32.sv | 70 +++++++
 rtl/mdu.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared constants and command decode helpers for the multiply/divide unit.
package mdu_pkg;

    // Conveyor geometry
    localparam int NUM_SLOTS = 8;
    localparam int CMD_W     = 88;

    // Unit identification on the conveyor
    localparam logic [2:0] UNIT_CODE = 3'd6;
    localparam logic [4:0] TAKE_TAG  = 5'd6;

    // Opcodes handled by this unit
    localparam logic [7:0] OP_MUL   = 8'h30;
    localparam logic [7:0] OP_MULHU = 8'h31;
    localparam logic [7:0] OP_DIVU  = 8'h32;
    localparam logic [7:0] OP_REMU  = 8'h33;

    // Completion status codes
    localparam logic [2:0] STAMP_DONE    = 3'b001;
    localparam logic [2:0] STAMP_DIV0    = 3'b010;
    localparam logic [2:0] STAMP_ILLEGAL = 3'b011;

    // Command field positions (LSB of each field)
    localparam int OPC_LSB = 80;
    localparam int RD_LSB  = 75;
    localparam int RS1_LSB = 70;
    localparam int RS2_LSB = 65;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    // Decoded view of a conveyor command
    typedef struct packed {
        logic [7:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } mdu_cmd_t;

    function automatic mdu_cmd_t decode_cmd(input logic [CMD_W-1:0] cmd);
        mdu_cmd_t c;
        c.opcode = cmd[OPC_LSB +: 8];
        c.rd     = cmd[RD_LSB  +: 5];
        c.rs1    = cmd[RS1_LSB +: 5];
        c.rs2    = cmd[RS2_LSB +: 5];
        return c;
    endfunction

    function automatic logic op_is_div(input logic [7:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic op_is_legal(input logic [7:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || op_is_div(op);
    endfunction

endpackage

// File: rtl/mdu_div32.sv
// 32-cycle unsigned restoring divider. A start pulse while idle loads the
// operands; the unit then stays busy for exactly 32 cycles, shifting one
// dividend bit (MSB first) into a 33-bit partial remainder each cycle.
// done is raised in the 32nd busy cycle; quotient/remainder are valid from
// the following cycle and hold until the next start.
module mdu_div32
    import mdu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic [4:0]  r_cnt;
    logic        r_busy;

    logic [32:0] w_shift;
    logic [33:0] w_diff;
    logic        w_fits;
    logic        w_unused_rem_msb;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        w_shift = {r_rem[31:0], r_quo[31]};
        w_diff  = {1'b0, w_shift} - {2'b00, r_div};
        w_fits  = ~w_diff[33];
    end

    // Iteration registers: load on start, one restoring step per busy cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start && !r_busy) begin
            r_rem  <= '0;
            r_quo  <= i_dividend;
            r_div  <= i_divisor;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem  <= w_fits ? w_diff[32:0] : w_shift;
            r_quo  <= {r_quo[30:0], w_fits};
            r_cnt  <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
                r_busy <= 1'b0;
            end
        end
    end

    // The remainder never exceeds the divisor, so its top bit is always 0
    assign w_unused_rem_msb = r_rem[32];

    assign o_busy      = r_busy;
    assign o_done      = r_busy && (r_cnt == 5'd31);
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem[31:0];

endmodule

// File: rtl/mdu.sv
// Multiply/divide responder on the conveyor dispatch bus.
// Handshake: in IDLE the unit claims the lowest slot tagged with its unit
// code by pulsing take_in[i] for one cycle (the claim is accepted on that
// clock edge, no back-pressure). After execution it pulses stamp_in[i] for
// one cycle together with the status on stamp_flat; the conveyor clears the
// slot's unit code on that same edge. One instruction in flight at a time.
module mdu
    import mdu_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3*NUM_SLOTS-1:0]       reg_start_flat,
    input  logic [CMD_W*NUM_SLOTS-1:0]   reg_out_flat,
    output logic [NUM_SLOTS-1:0]         take_in,
    output logic [5*NUM_SLOTS-1:0]       take_flat,
    output logic [NUM_SLOTS-1:0]         stamp_in,
    output logic [3*NUM_SLOTS-1:0]       stamp_flat,
    output logic [4:0]                   reg_search_out12,
    input  logic [31:0]                  reg_out12,
    output logic [4:0]                   reg_search_out13,
    input  logic [31:0]                  reg_out13,
    output logic [4:0]                   reg_search_in12,
    output logic [31:0]                  reg_in12,
    output logic                         reg_in12_start,
    output logic [1:0]                   o_dbg_state
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nx;

    logic [2:0]  r_slot;
    logic [7:0]  r_op;
    logic [4:0]  r_rd;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_status;
    logic [31:0] r_result;

    logic        w_hit;
    logic [2:0]  w_sel;
    mdu_cmd_t    w_cmd;
    logic        w_claim;
    logic [2:0]  w_new_status;
    logic        w_div_start;

    logic [63:0] w_prod;
    logic [31:0] w_exec_result;
    logic [31:0] w_wb_data;

    logic        w_div_busy;
    logic        w_div_done;
    logic [31:0] w_div_quo;
    logic [31:0] w_div_rem;
    logic        w_unused_ok;

    // Priority pick: lowest-index slot carrying this unit's code
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (reg_start_flat[3*i +: 3] == UNIT_CODE) begin
                w_hit = 1'b1;
                w_sel = 3'(i);
            end
        end
    end

    assign w_cmd = decode_cmd(reg_out_flat[CMD_W*w_sel +: CMD_W]);

    // Claims are suppressed while reset is held so every output reads 0
    assign w_claim = (r_state == ST_IDLE) && w_hit && !reset;

    // Status is known at claim time: bad opcode or zero divisor
    always_comb begin
        w_new_status = STAMP_DONE;
        if (!op_is_legal(w_cmd.opcode)) begin
            w_new_status = STAMP_ILLEGAL;
        end else if (op_is_div(w_cmd.opcode) && (reg_out13 == 32'd0)) begin
            w_new_status = STAMP_DIV0;
        end
    end

    // The divider is launched on the claim edge so it finishes on T+32
    assign w_div_start = w_claim && op_is_div(w_cmd.opcode) && (reg_out13 != 32'd0);

    // Claim-side outputs: take pulse, tag and register read addresses
    always_comb begin
        take_in          = '0;
        take_flat        = '0;
        reg_search_out12 = '0;
        reg_search_out13 = '0;
        if (w_claim) begin
            take_in[w_sel]           = 1'b1;
            take_flat[5*w_sel +: 5]  = TAKE_TAG;
            reg_search_out12         = w_cmd.rs1;
            reg_search_out13         = w_cmd.rs2;
        end
    end

    // Latch the claimed instruction and its operands
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot   <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_status <= '0;
        end else if (w_claim) begin
            r_slot   <= w_sel;
            r_op     <= w_cmd.opcode;
            r_rd     <= w_cmd.rd;
            r_a      <= reg_out12;
            r_b      <= reg_out13;
            r_status <= w_new_status;
        end
    end

    // Single-cycle multiply and the fixed divide-by-zero results
    always_comb begin
        w_prod = {32'd0, r_a} * {32'd0, r_b};
        case (r_op)
            OP_MUL:   w_exec_result = w_prod[31:0];
            OP_MULHU: w_exec_result = w_prod[63:32];
            OP_DIVU:  w_exec_result = 32'hFFFF_FFFF;
            OP_REMU:  w_exec_result = r_a;
            default:  w_exec_result = 32'd0;
        endcase
    end

    // Capture the non-iterative result at the end of EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
        end else if (r_state == ST_EXEC) begin
            r_result <= w_exec_result;
        end
    end

    mdu_div32 u_div (
        .i_clk       (clk),
        .i_rst       (reset),
        .i_start     (w_div_start),
        .i_dividend  (reg_out12),
        .i_divisor   (reg_out13),
        .o_busy      (w_div_busy),
        .o_done      (w_div_done),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem)
    );

    assign w_unused_ok = w_div_busy;

    // Next-state logic: IDLE -> EXEC/WB, EXEC waits on the divider if needed
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_claim) begin
                    w_state_nx = op_is_legal(w_cmd.opcode) ? ST_EXEC : ST_WB;
                end
            end
            ST_EXEC: begin
                if (!op_is_div(r_op) || (r_status == STAMP_DIV0) || w_div_done) begin
                    w_state_nx = ST_WB;
                end
            end
            ST_WB:   w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // A real divide takes its result from the divider, everything else from r_result
    assign w_wb_data = (op_is_div(r_op) && (r_status == STAMP_DONE))
                     ? ((r_op == OP_DIVU) ? w_div_quo : w_div_rem)
                     : r_result;

    // Writeback-side outputs: register write and completion stamp
    always_comb begin
        stamp_in        = '0;
        stamp_flat      = '0;
        reg_in12_start  = 1'b0;
        reg_search_in12 = '0;
        reg_in12        = '0;
        if (r_state == ST_WB) begin
            stamp_in[r_slot]           = 1'b1;
            stamp_flat[3*r_slot +: 3]  = r_status;
            if (r_status != STAMP_ILLEGAL) begin
                reg_in12_start  = 1'b1;
                reg_search_in12 = r_rd;
                reg_in12        = w_wb_data;
            end
        end
    end

    assign o_dbg_state = r_state;

endmodule
